i2c_target_receiver: RTL and testbench



---
 rtl/i2c_pkg.sv | 24 ++
 rtl/i2c_target_receiver_if.sv | 20 ++
 rtl/i2c_bus_sampler.sv | 75 +++++++
 rtl/i2c_target_receiver.sv | 206 ++++++++++++++++++++
 tb/tb_i2c_target_receiver.sv | 265 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/i2c_pkg.sv
// Shared types and constants for the I2C target receiver.
// Optional glitch filter in the bus sampler: I2C_TARGET_GLITCH_FILTER_EN.
package i2c_pkg;

    localparam int ADDR_W = 7;
    localparam int BYTE_W = 8;

    typedef enum logic [2:0] {
        IDLE,
        ADDR,
        ADDR_ACK,
        WR_BYTE,
        WR_ACK,
        RD_BYTE,
        RD_ACK,
        WAIT_STOP
    } state_e;

    // Two-of-three vote used by the optional glitch filter
    function automatic logic majority3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/i2c_target_receiver_if.sv
// Bus-side signals shared between the I2C master transmitter and this target.
interface i2c_target_receiver_if;

    logic SCL;         // bus clock from the master
    logic SDA_OUT;     // master SDA drive value
    logic SDA_OE;      // master SDA output enable
    logic SDA_IN;      // target data bit back to the master, 1 = released
    logic SDA_IN_ACK;  // high while the target drives an ACK slot

    modport master (
        output SCL, SDA_OUT, SDA_OE,
        input  SDA_IN, SDA_IN_ACK
    );

    modport slave (
        input  SCL, SDA_OUT, SDA_OE,
        output SDA_IN, SDA_IN_ACK
    );

endinterface

// File: rtl/i2c_bus_sampler.sv
// Oversamples SCL/SDA, optionally filters them, and flags SCL edges and
// START/STOP conditions. Filter enabled by I2C_TARGET_GLITCH_FILTER_EN
// (2-flop synchroniser + 3-sample majority, adds 3 clk of latency).
module i2c_bus_sampler
    import i2c_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic scl_raw,
    input  logic sda_raw,
    output logic sda,
    output logic scl_rise,
    output logic scl_fall,
    output logic start,
    output logic stop
);

    logic scl;
    logic scl_q, scl_d;
    logic sda_q, sda_d;

    // Previous-sample registers used for edge detection; idle bus is high
    always_ff @(posedge clk) begin
        // NOTE: flops use non-blocking assignments so every register samples the pre-edge values.
        if (!rst) begin
            scl_q <= 1'b1;
            sda_q <= 1'b1;
        end else begin
            scl_q <= scl_d;
            sda_q <= sda_d;
        end
    end

`ifdef I2C_TARGET_GLITCH_FILTER_EN
    // [0],[1] synchronise; [1..3] form the vote window
    logic [3:0] scl_pipe_q, scl_pipe_d;
    logic [3:0] sda_pipe_q, sda_pipe_d;

    // Advance the sample pipelines and vote on the settled samples
    always_comb begin
        scl_pipe_d = {scl_pipe_q[2:0], scl_raw};
        sda_pipe_d = {sda_pipe_q[2:0], sda_raw};
        scl        = majority3(scl_pipe_q[1], scl_pipe_q[2], scl_pipe_q[3]);
        sda        = majority3(sda_pipe_q[1], sda_pipe_q[2], sda_pipe_q[3]);
    end

    // Pipeline registers start at the idle-high bus level
    always_ff @(posedge clk) begin
        if (!rst) begin
            scl_pipe_q <= '1;
            sda_pipe_q <= '1;
        end else begin
            scl_pipe_q <= scl_pipe_d;
            sda_pipe_q <= sda_pipe_d;
        end
    end
`else
    // Raw levels feed edge detection directly
    always_comb begin
        scl = scl_raw;
        sda = sda_raw;
    end
`endif

    // Edge and bus-condition decode against the previous samples
    always_comb begin
        scl_d    = scl;
        sda_d    = sda;
        scl_rise = !scl_q & scl;
        scl_fall = scl_q & !scl;
        start    = scl & scl_q & sda_q & !sda;
        stop     = scl & scl_q & !sda_q & sda;
    end

endmodule

// File: rtl/i2c_target_receiver.sv
// I2C target endpoint: address match with ACK, multi-byte write capture and
// MSB-first read-back of a host word. Optional input glitch filter enabled
// by I2C_TARGET_GLITCH_FILTER_EN (inside i2c_bus_sampler).
module i2c_target_receiver
    import i2c_pkg::*;
#(
    parameter int DATA_WIDTH = 16,
    parameter int BYTE_CNT_W = 2
)(
    input  logic                  clk,
    input  logic                  rst,
    i2c_target_receiver_if.slave  bus,
    input  logic [ADDR_W-1:0]     I2C_ADDR,
    input  logic [DATA_WIDTH-1:0] RD_DATA,
    output logic [DATA_WIDTH-1:0] WR_DATA,
    output logic                  WR_STB,
    output logic                  BUSY
);

    localparam int                    NUM_BYTES = DATA_WIDTH / BYTE_W;
    localparam logic [BYTE_CNT_W-1:0] LAST_BYTE = BYTE_CNT_W'(NUM_BYTES - 1);
    localparam logic [3:0]            BIT_LAST  = 4'(BYTE_W);

    logic sda_eff, sda, scl_rise, scl_fall, start, stop;

    state_e                state_q, state_d;
    logic [3:0]            bit_cnt_q, bit_cnt_d;
    logic [BYTE_CNT_W-1:0] byte_cnt_q, byte_cnt_d;
    logic [BYTE_W-1:0]     shift_q, shift_d;
    logic [DATA_WIDTH-1:0] wr_acc_q, wr_acc_d;
    logic [DATA_WIDTH-1:0] rd_shift_q, rd_shift_d;
    logic [DATA_WIDTH-1:0] wr_data_q, wr_data_d;
    logic                  rw_q, rw_d;
    logic                  nack_q, nack_d;
    logic                  sda_in_q, sda_in_d;
    logic                  sda_in_ack_q, sda_in_ack_d;
    logic                  wr_stb_q, wr_stb_d;

    // Unenabled master driver leaves the line to the pull-up
    assign sda_eff = bus.SDA_OE ? bus.SDA_OUT : 1'b1;

    i2c_bus_sampler u_sampler (
        .clk      (clk),
        .rst      (rst),
        .scl_raw  (bus.SCL),
        .sda_raw  (sda_eff),
        .sda      (sda),
        .scl_rise (scl_rise),
        .scl_fall (scl_fall),
        .start    (start),
        .stop     (stop)
    );

    // Next-state and output decode; bits sampled on SCL rise, outputs moved on SCL fall
    always_comb begin
        // NOTE: every variable gets a default first so no path leaves one unassigned (no latches).
        state_d      = state_q;
        bit_cnt_d    = bit_cnt_q;
        byte_cnt_d   = byte_cnt_q;
        shift_d      = shift_q;
        wr_acc_d     = wr_acc_q;
        rd_shift_d   = rd_shift_q;
        wr_data_d    = wr_data_q;
        rw_d         = rw_q;
        nack_d       = nack_q;
        sda_in_d     = sda_in_q;
        sda_in_ack_d = sda_in_ack_q;
        wr_stb_d     = 1'b0;

        if (start || (stop && state_q != IDLE)) begin
            // (Repeated) START restarts addressing; STOP ends the transfer; partial words dropped
            state_d      = start ? ADDR : IDLE;
            bit_cnt_d    = '0;
            byte_cnt_d   = '0;
            shift_d      = '0;
            wr_acc_d     = '0;
            sda_in_d     = 1'b1;
            sda_in_ack_d = 1'b0;
        end else begin
            unique case (state_q)
                IDLE: ;
                ADDR, WR_BYTE: begin
                    if (scl_rise) begin
                        shift_d   = {shift_q[BYTE_W-2:0], sda};
                        bit_cnt_d = bit_cnt_q + 4'd1;
                    end else if (scl_fall && bit_cnt_q == BIT_LAST) begin
                        bit_cnt_d = '0;
                        if (state_q == WR_BYTE) begin
                            wr_acc_d     = (wr_acc_q << BYTE_W) | DATA_WIDTH'(shift_q);
                            sda_in_d     = 1'b0;
                            sda_in_ack_d = 1'b1;
                            state_d      = WR_ACK;
                        end else if (shift_q[BYTE_W-1:1] == I2C_ADDR) begin
                            rw_d         = shift_q[0];
                            sda_in_d     = 1'b0;
                            sda_in_ack_d = 1'b1;
                            state_d      = ADDR_ACK;
                        end else begin
                            sda_in_d = 1'b1;
                            state_d  = WAIT_STOP;
                        end
                    end
                end
                ADDR_ACK: begin
                    if (scl_fall) begin
                        sda_in_ack_d = 1'b0;
                        byte_cnt_d   = '0;
                        if (rw_q) begin
                            rd_shift_d = RD_DATA;
                            sda_in_d   = RD_DATA[DATA_WIDTH-1];
                            bit_cnt_d  = 4'd1;
                            state_d    = RD_BYTE;
                        end else begin
                            sda_in_d  = 1'b1;
                            bit_cnt_d = '0;
                            state_d   = WR_BYTE;
                        end
                    end
                end
                WR_ACK: begin
                    if (scl_fall) begin
                        sda_in_d     = 1'b1;
                        sda_in_ack_d = 1'b0;
                        if (byte_cnt_q == LAST_BYTE) begin
                            wr_data_d = wr_acc_q;
                            wr_stb_d  = 1'b1;
                            state_d   = WAIT_STOP;
                        end else begin
                            byte_cnt_d = byte_cnt_q + BYTE_CNT_W'(1);
                            state_d    = WR_BYTE;
                        end
                    end
                end
                RD_BYTE: begin
                    if (scl_fall) begin
                        if (bit_cnt_q == BIT_LAST) begin
                            sda_in_d  = 1'b1;
                            bit_cnt_d = '0;
                            nack_d    = 1'b1;
                            state_d   = RD_ACK;
                        end else begin
                            rd_shift_d = rd_shift_q << 1;
                            sda_in_d   = rd_shift_q[DATA_WIDTH-2];
                            bit_cnt_d  = bit_cnt_q + 4'd1;
                        end
                    end
                end
                RD_ACK: begin
                    if (scl_rise) begin
                        nack_d = sda;
                    end else if (scl_fall) begin
                        if (nack_q || byte_cnt_q == LAST_BYTE) begin
                            state_d = WAIT_STOP;
                        end else begin
                            byte_cnt_d = byte_cnt_q + BYTE_CNT_W'(1);
                            rd_shift_d = rd_shift_q << 1;
                            sda_in_d   = rd_shift_q[DATA_WIDTH-2];
                            bit_cnt_d  = 4'd1;
                            state_d    = RD_BYTE;
                        end
                    end
                end
                WAIT_STOP: sda_in_d = 1'b1;
                default:   state_d = IDLE;
            endcase
        end
    end

    // State and registered outputs, synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q      <= IDLE;
            bit_cnt_q    <= '0;
            byte_cnt_q   <= '0;
            shift_q      <= '0;
            wr_acc_q     <= '0;
            rd_shift_q   <= '0;
            wr_data_q    <= '0;
            rw_q         <= 1'b0;
            nack_q       <= 1'b0;
            sda_in_q     <= 1'b1;
            sda_in_ack_q <= 1'b0;
            wr_stb_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            bit_cnt_q    <= bit_cnt_d;
            byte_cnt_q   <= byte_cnt_d;
            shift_q      <= shift_d;
            wr_acc_q     <= wr_acc_d;
            rd_shift_q   <= rd_shift_d;
            wr_data_q    <= wr_data_d;
            rw_q         <= rw_d;
            nack_q       <= nack_d;
            sda_in_q     <= sda_in_d;
            sda_in_ack_q <= sda_in_ack_d;
            wr_stb_q     <= wr_stb_d;
        end
    end

    assign bus.SDA_IN     = sda_in_q;
    assign bus.SDA_IN_ACK = sda_in_ack_q;
    assign WR_DATA        = wr_data_q;
    assign WR_STB         = wr_stb_q;
    assign BUSY           = (state_q != IDLE);

endmodule

// File: tb/tb_i2c_target_receiver.sv
// Directed bench for i2c_target_receiver: a bit-level I2C master model, a
// table of whole transactions, and hand-written repeated-START, mid-transfer
// reset and SCL glitch sequences (glitch outcome depends on
// I2C_TARGET_GLITCH_FILTER_EN).
module tb_i2c_target_receiver;

    localparam int Q = 6;  // clk cycles per quarter SCL period

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [6:0]  i2c_addr;
    logic [15:0] rd_data;
    logic [15:0] wr_data;
    logic        wr_stb;
    logic        busy;

    int checks   = 0;
    int failures = 0;
    int stb_cnt  = 0;
    int ack_cyc  = 0;
    int low_cyc  = 0;

    always #5 clk = ~clk;

    i2c_target_receiver_if bus();

    i2c_target_receiver #(.DATA_WIDTH(16), .BYTE_CNT_W(2)) dut (
        .clk      (clk),
        .rst      (rst),
        .bus      (bus),
        .I2C_ADDR (i2c_addr),
        .RD_DATA  (rd_data),
        .WR_DATA  (wr_data),
        .WR_STB   (wr_stb),
        .BUSY     (busy)
    );

    // Output monitors sampled away from the active edge
    always @(negedge clk) begin
        if (wr_stb)         stb_cnt++;
        if (bus.SDA_IN_ACK) ack_cyc++;
        if (!bus.SDA_IN)    low_cyc++;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    // One SCL period; samples the target outputs a quarter period into SCL high
    task automatic bus_bit(input logic drive, input logic b, input logic glitch,
                           output logic sda_seen, output logic ack_seen);
        bus.SDA_OE  = drive;
        bus.SDA_OUT = b;
        tick(Q);
        bus.SCL = 1'b1;
        tick(Q);
        sda_seen = bus.SDA_IN;
        ack_seen = bus.SDA_IN_ACK;
        if (glitch) begin
            bus.SCL = 1'b0;
            tick(1);
            bus.SCL = 1'b1;
        end
        tick(Q);
        bus.SCL = 1'b0;
        tick(Q);
    endtask

    task automatic i2c_start();
        bus.SDA_OE  = 1'b1;
        bus.SDA_OUT = 1'b1;
        tick(Q);
        bus.SCL = 1'b1;
        tick(Q);
        bus.SDA_OUT = 1'b0;
        tick(Q);
        bus.SCL = 1'b0;
        tick(Q);
    endtask

    task automatic i2c_stop();
        bus.SDA_OE  = 1'b1;
        bus.SDA_OUT = 1'b0;
        tick(Q);
        bus.SCL = 1'b1;
        tick(Q);
        bus.SDA_OUT = 1'b1;
        tick(Q);
        bus.SDA_OE = 1'b0;
        tick(Q);
    endtask

    task automatic send_byte(input logic [7:0] v, input int glitch_bit,
                             output logic ack_sda, output logic ack_flag);
        logic s, a;
        for (int i = 0; i < 8; i++) bus_bit(1'b1, v[7-i], (i == glitch_bit), s, a);
        bus_bit(1'b0, 1'b1, 1'b0, ack_sda, ack_flag);
    endtask

    task automatic recv_byte(input logic master_nack, output logic [7:0] v,
                             output logic slot_sda, output logic slot_flag);
        logic s, a;
        for (int i = 0; i < 8; i++) begin
            bus_bit(1'b0, 1'b1, 1'b0, s, a);
            v[7-i] = s;
        end
        bus_bit(!master_nack, master_nack, 1'b0, slot_sda, slot_flag);
    endtask

    typedef struct {
        string       name;
        logic [6:0]  tgt_addr;
        logic [6:0]  bus_addr;
        logic        rw;
        logic [15:0] data;       // write payload or RD_DATA
        logic [2:0]  exp_sda;    // SDA_IN in ack slots {byte2, byte1, addr}
        logic [2:0]  exp_flag;   // SDA_IN_ACK in ack slots
        logic [15:0] exp_rd;     // word seen by the master on a read
        logic [15:0] exp_wr;     // WR_DATA after the transfer
        int          exp_stb;
    } vec_t;

    vec_t vecs[6];

    initial begin
        logic [2:0] sda_v, flag_v;
        logic [7:0] hi, lo;
        logic       s, f;

        vecs[0] = '{"wr_beef",    7'h2A, 7'h2A, 1'b0, 16'hBEEF, 3'b000, 3'b111, 16'h0000, 16'hBEEF, 1};
        vecs[1] = '{"rd_a55a",    7'h2A, 7'h2A, 1'b1, 16'hA55A, 3'b110, 3'b001, 16'hA55A, 16'hBEEF, 0};
        vecs[2] = '{"wr_nomatch", 7'h2A, 7'h11, 1'b0, 16'h1234, 3'b111, 3'b000, 16'h0000, 16'hBEEF, 0};
        vecs[3] = '{"wr_addr7f",  7'h7F, 7'h7F, 1'b0, 16'h0001, 3'b000, 3'b111, 16'h0000, 16'h0001, 1};
        vecs[4] = '{"rd_addr00",  7'h00, 7'h00, 1'b1, 16'hFFFF, 3'b110, 3'b001, 16'hFFFF, 16'h0001, 0};
        vecs[5] = '{"rd_nomatch", 7'h2A, 7'h2B, 1'b1, 16'h1234, 3'b111, 3'b000, 16'hFFFF, 16'h0001, 0};

        bus.SCL     = 1'b1;
        bus.SDA_OE  = 1'b0;
        bus.SDA_OUT = 1'b1;
        i2c_addr    = 7'h2A;
        rd_data     = 16'h0;
        rst         = 1'b0;
        tick(3);
        check("reset_sda_in",  32'(bus.SDA_IN), 32'd1);
        check("reset_ack",     32'(bus.SDA_IN_ACK), 32'd0);
        check("reset_wr_data", 32'(wr_data), 32'd0);
        check("reset_wr_stb",  32'(wr_stb), 32'd0);
        check("reset_busy",    32'(busy), 32'd0);
        rst = 1'b1;
        tick(2);

        // Whole transactions from the table
        for (int k = 0; k < 6; k++) begin
            i2c_addr = vecs[k].tgt_addr;
            rd_data  = vecs[k].rw ? vecs[k].data : 16'h0;
            stb_cnt  = 0;
            ack_cyc  = 0;
            low_cyc  = 0;
            i2c_start();
            send_byte({vecs[k].bus_addr, vecs[k].rw}, -1, sda_v[0], flag_v[0]);
            if (vecs[k].rw) begin
                recv_byte(1'b0, hi, sda_v[1], flag_v[1]);
                recv_byte(1'b1, lo, sda_v[2], flag_v[2]);
                check({vecs[k].name, "_rd_word"}, 32'({hi, lo}), 32'(vecs[k].exp_rd));
            end else begin
                send_byte(vecs[k].data[15:8], -1, sda_v[1], flag_v[1]);
                send_byte(vecs[k].data[7:0],  -1, sda_v[2], flag_v[2]);
            end
            check({vecs[k].name, "_busy_mid"}, 32'(busy), 32'd1);
            i2c_stop();
            check({vecs[k].name, "_ack_sda"},  32'(sda_v),  32'(vecs[k].exp_sda));
            check({vecs[k].name, "_ack_flag"}, 32'(flag_v), 32'(vecs[k].exp_flag));
            check({vecs[k].name, "_ack_any"},  32'(ack_cyc != 0), 32'(vecs[k].exp_flag != 0));
            check({vecs[k].name, "_low_any"},  32'(low_cyc != 0), 32'(vecs[k].exp_flag != 0));
            check({vecs[k].name, "_wr_data"},  32'(wr_data), 32'(vecs[k].exp_wr));
            check({vecs[k].name, "_stb_cnt"},  32'(stb_cnt), 32'(vecs[k].exp_stb));
            check({vecs[k].name, "_busy_end"}, 32'(busy), 32'd0);
            check({vecs[k].name, "_sda_end"},  32'(bus.SDA_IN), 32'd1);
        end

        // Partial write then repeated START: only the second write lands
        i2c_addr = 7'h2A;
        stb_cnt  = 0;
        i2c_start();
        send_byte({7'h2A, 1'b0}, -1, s, f);
        send_byte(8'h12, -1, s, f);
        i2c_start();
        send_byte({7'h2A, 1'b0}, -1, s, f);
        check("rstart_addr_ack", 32'(s), 32'd0);
        send_byte(8'h34, -1, s, f);
        send_byte(8'h56, -1, s, f);
        i2c_stop();
        check("rstart_stb_cnt", 32'(stb_cnt), 32'd1);
        check("rstart_wr_data", 32'(wr_data), 32'h3456);

        // Reset in the middle of a data byte, then a clean write
        i2c_start();
        send_byte({7'h2A, 1'b0}, -1, s, f);
        for (int i = 0; i < 4; i++) bus_bit(1'b1, i[0], 1'b0, s, f);
        check("midrst_busy_before", 32'(busy), 32'd1);
        rst = 1'b0;
        tick(1);
        check("midrst_sda_in",  32'(bus.SDA_IN), 32'd1);
        check("midrst_ack",     32'(bus.SDA_IN_ACK), 32'd0);
        check("midrst_wr_data", 32'(wr_data), 32'd0);
        check("midrst_wr_stb",  32'(wr_stb), 32'd0);
        check("midrst_busy",    32'(busy), 32'd0);
        rst        = 1'b1;
        bus.SDA_OE = 1'b0;
        bus.SCL    = 1'b1;
        tick(2 * Q);
        stb_cnt = 0;
        i2c_start();
        send_byte({7'h2A, 1'b0}, -1, s, f);
        check("postrst_addr_ack", 32'(s), 32'd0);
        send_byte(8'h0F, -1, s, f);
        send_byte(8'h0F, -1, s, f);
        i2c_stop();
        check("postrst_wr_data", 32'(wr_data), 32'h0F0F);
        check("postrst_stb_cnt", 32'(stb_cnt), 32'd1);

        // One-clock SCL low pulse inside the address byte
        stb_cnt = 0;
        i2c_start();
        send_byte({7'h2A, 1'b0}, 3, s, f);
`ifdef I2C_TARGET_GLITCH_FILTER_EN
        check("glitch_addr_ack_sda",  32'(s), 32'd0);
        check("glitch_addr_ack_flag", 32'(f), 32'd1);
        send_byte(8'hC3, -1, s, f);
        send_byte(8'h3C, -1, s, f);
        i2c_stop();
        check("glitch_wr_data", 32'(wr_data), 32'hC33C);
        check("glitch_stb_cnt", 32'(stb_cnt), 32'd1);
`else
        // Unfiltered, the glitch adds a bit: 0x5A is shifted in, address 0x2D misses
        check("glitch_addr_ack_sda",  32'(s), 32'd1);
        check("glitch_addr_ack_flag", 32'(f), 32'd0);
        send_byte(8'hC3, -1, s, f);
        send_byte(8'h3C, -1, s, f);
        i2c_stop();
        check("glitch_wr_data", 32'(wr_data), 32'h0F0F);
        check("glitch_stb_cnt", 32'(stb_cnt), 32'd0);
`endif
        check("final_busy", 32'(busy), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Run-time bound in case the DUT or bench stalls
    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation exceeded time limit, checks=%0d", checks);
        $fatal(1, "watchdog expired");
    end

endmodule
